ab_byte_unit: RTL and testbench
===============================

// Module: ab_byte_unit
// PURPOSE
//  Parametrised address-bus byte slice: computes next address byte AD, registers it as AB,
//  and holds the matching program-counter byte PC. It is used for both the ABL and ABH
//  slices of the CPU address path. Adds a page-cross fixup sequencer: a deferred carry is
//  presented as a second cycle with a stall flag. Also adds a temp register for indirect
//  targets and a hold op.
// PARAMETERS
//  W         8      slice width in bits
//  RST_AB    all-1  AB value after reset (W bits)
//  RST_PC    0      PC value after reset (W bits)
// PORTS
//  clk      in   1    clock, all state on rising edge
//  rst_n    in   1    async active-low reset
//  ff       in   1    force AD to all-ones (vector fetch); highest priority
//  ci       in   1    carry in from lower slice
//  db       in   W    data bus
//  op       in   4    next-address operation, see table
//  fix_en   in   1    defer ci into a fixup cycle (indexed page-cross)
//  ld_tmp   in   1    TMP <= db
//  ld_pc    in   1    PC <= AB + inc_pc
//  inc_pc   in   1    increment for PC load
//  ad       out  W    unregistered next address byte
//  ab       out  W    registered address byte
//  pc       out  W    program counter byte
//  co       out  1    combinational carry out of the AD sum (bit W)
//  stall    out  1    high while the FSM is in FIXUP (controller must hold its sequence)
// BEHAVIOUR
//  - Reset (async, rst_n=0): AB=RST_AB, PC=RST_PC, TMP=0, state=IDLE. Then stall=0, co per comb.
//  - Sum is W+1 bits: {co,ad} = A + B + c. Operand table:
//      0???: 0+0+c   1000: AB+0+c   1001: AB+ones+c   1010: PC+0+c
//      1011: DB+0+c  1100: TMP+0+c  1101: AB (hold, c ignored, co=0)  111?: reserved = hold
//  - c = ci in IDLE when fix_en=0; c = 0 in IDLE when fix_en=1. In IDLE with fix_en=1 and ci=1,
//    the next state is FIXUP.
//  - FIXUP: op and fix_en are ignored; {co,ad} = AB + 1. stall=1. The next state is always IDLE.
//    FIXUP lasts exactly one cycle.
//  - ff=1 (any state): ad = all-ones, co=0, next state IDLE, deferred carry discarded.
//  - Every cycle: AB <= ad (rst_n=1).
//  - ld_pc: PC <= AB + inc_pc, mod 2^W. It uses the current registered AB, independent of ff
//    and FSM state. PC wraps all-ones -> 0.
//  - ld_tmp: TMP <= db. It is independent of all other controls. Same-cycle op 1100 reads the
//    old TMP.
//  - Wrap: AB + ones + 0 with AB=0 gives ad=all-ones, co=0. AB + 1 with AB=all-ones gives
//    ad=0, co=1.
//  - Reset mid-FIXUP: the state returns to IDLE immediately and stall drops asynchronously.
// STRUCTURE
//  - Package ab_pkg: localparams for the op codes (OP_ZERO, OP_AB, OP_ABM1, OP_PC, OP_DB,
//    OP_TMP, OP_HOLD) and the FSM state encoding (ST_IDLE, ST_FIXUP).
//  - One sub-module, ab_sum: operand mux + (W+1)-bit adder, purely combinational
//    (inputs: sel, AB, PC, DB, TMP, c; outputs: ad, co).
//  - Top level holds the AB, PC and TMP registers and the 2-state FSM.
// TESTING (W=8 unless noted)
//  1. Reset: rst_n=0 -> ab=FF, pc=00, stall=0. Release, op=0000 ci=1 -> ad=01, ab=01 next cycle.
//  2. Page-cross: ab=12, op=1011 db=34 ci=1 fix_en=1 -> ad=34, ab=34, stall=1.
//     Then ad=35, ab=35, stall=0 (any op).
//  3. No cross: the same as test 2 with ci=0 -> ad=34, no stall. Op 1001 with ab=00 ci=0
//     -> ad=FF, co=0.
//  4. PC: ab=FF ld_pc=1 inc_pc=1 -> pc=00. ab=7F inc_pc=0 -> pc=7F. ld_pc with ff=1 uses the
//     old ab.
//  5. ff during FIXUP: enter FIXUP (ab=10), assert ff -> ad=FF, ab=FF, stall=0, no 11 emitted.
//  6. Reset mid-FIXUP, plus W=16: ld_tmp db=ABCD, op=1100 ci=1 -> ad=ABCE. Drop rst_n while
//     stall=1 -> stall=0, ab=FFFF.

Source files
------------

// File: rtl/ab_pkg.sv
// Shared op codes and FSM state encoding for the address-bus byte slice.
package ab_pkg;

  localparam int unsigned OP_W = 4;

  // Next-address operations; any op with bit 3 clear selects 0+0+c, and 111x acts as hold.
  localparam logic [OP_W-1:0] OP_ZERO = 4'b0000;
  localparam logic [OP_W-1:0] OP_AB   = 4'b1000;
  localparam logic [OP_W-1:0] OP_ABM1 = 4'b1001;
  localparam logic [OP_W-1:0] OP_PC   = 4'b1010;
  localparam logic [OP_W-1:0] OP_DB   = 4'b1011;
  localparam logic [OP_W-1:0] OP_TMP  = 4'b1100;
  localparam logic [OP_W-1:0] OP_HOLD = 4'b1101;

  // Page-cross fixup sequencer states.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FIXUP = 1'b1
  } ab_state_e;

endpackage

// File: rtl/ab_sum.sv
// Operand mux and (W+1)-bit adder producing the next address byte and its carry.
module ab_sum
  import ab_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic [OP_W-1:0] i_sel,
  input  logic [W-1:0]    i_ab,
  input  logic [W-1:0]    i_pc,
  input  logic [W-1:0]    i_db,
  input  logic [W-1:0]    i_tmp,
  input  logic            i_c,
  output logic [W-1:0]    o_ad,
  output logic            o_co
);

  localparam int unsigned SW = W + 1;

  logic [W-1:0]  w_a;
  logic [W-1:0]  w_b;
  logic          w_c;
  logic [SW-1:0] w_sum;

  // Select A/B operands and carry; hold and reserved ops pass AB with no carry.
  always_comb begin
    w_a = '0;
    w_b = '0;
    w_c = i_c;
    if (i_sel[3]) begin
      case (i_sel)
        OP_AB:   w_a = i_ab;
        OP_ABM1: begin
          w_a = i_ab;
          w_b = '1;
        end
        OP_PC:   w_a = i_pc;
        OP_DB:   w_a = i_db;
        OP_TMP:  w_a = i_tmp;
        default: begin
          w_a = i_ab;
          w_c = 1'b0;
        end
      endcase
    end
  end

  assign w_sum = SW'(w_a) + SW'(w_b) + SW'(w_c);
  assign o_ad  = w_sum[W-1:0];
  assign o_co  = w_sum[W];

endmodule

// File: rtl/ab_byte_unit.sv
// Address-bus byte slice: AB/PC/TMP registers plus a one-cycle page-cross fixup sequencer.
module ab_byte_unit
  import ab_pkg::*;
#(
  parameter int unsigned   W      = 8,
  parameter logic [W-1:0]  RST_AB = '1,
  parameter logic [W-1:0]  RST_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ff,
  input  logic            ci,
  input  logic [W-1:0]    db,
  input  logic [OP_W-1:0] op,
  input  logic            fix_en,
  input  logic            ld_tmp,
  input  logic            ld_pc,
  input  logic            inc_pc,
  output logic [W-1:0]    ad,
  output logic [W-1:0]    ab,
  output logic [W-1:0]    pc,
  output logic            co,
  output logic            stall
);

  ab_state_e       r_state;
  ab_state_e       w_state_nxt;
  logic [W-1:0]    r_ab;
  logic [W-1:0]    r_pc;
  logic [W-1:0]    r_tmp;
  logic [OP_W-1:0] w_sel;
  logic            w_c;
  logic [W-1:0]    w_sum_ad;
  logic            w_sum_co;

  // FSM state register; reset drops stall immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state and adder control: a deferred carry becomes AB+1 in the fixup cycle.
  always_comb begin
    w_state_nxt = ST_IDLE;
    w_sel       = op;
    w_c         = fix_en ? 1'b0 : ci;
    case (r_state)
      ST_IDLE: begin
        if (fix_en && ci && !ff) w_state_nxt = ST_FIXUP;
      end
      ST_FIXUP: begin
        w_sel = OP_AB;
        w_c   = 1'b1;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  ab_sum #(.W(W)) u_sum (
    .i_sel (w_sel),
    .i_ab  (r_ab),
    .i_pc  (r_pc),
    .i_db  (db),
    .i_tmp (r_tmp),
    .i_c   (w_c),
    .o_ad  (w_sum_ad),
    .o_co  (w_sum_co)
  );

  // Vector fetch overrides everything.
  assign ad    = ff ? '1 : w_sum_ad;
  assign co    = ff ? 1'b0 : w_sum_co;
  assign stall = (r_state == ST_FIXUP);
  assign ab    = r_ab;
  assign pc    = r_pc;

  // AB follows AD every cycle; PC loads from the current AB; TMP captures the data bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ab  <= RST_AB;
      r_pc  <= RST_PC;
      r_tmp <= '0;
    end else begin
      r_ab <= ad;
      if (ld_pc)  r_pc  <= r_ab + W'(inc_pc);
      if (ld_tmp) r_tmp <= db;
    end
  end

endmodule

// File: tb/tb_ab_byte_unit.sv
// Scoreboard bench for ab_byte_unit at W=8 and W=16.
module tb_ab_byte_unit;
  import ab_pkg::*;

  localparam int S_AD = 0;
  localparam int S_AB = 1;
  localparam int S_PC = 2;
  localparam int S_ST = 3;
  localparam int S_CO = 4;

  typedef struct {
    string       name;
    int          sig;
    logic [15:0] val;
    bit          w16;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // W=8 instance signals
  logic        rst8_n, ff8, ci8, fix8, ldt8, ldp8, inc8;
  logic [7:0]  db8;
  logic [3:0]  op8;
  logic [7:0]  ad8, ab8, pc8;
  logic        co8, st8;

  // W=16 instance signals
  logic        rst16_n, ff16, ci16, fix16, ldt16, ldp16, inc16;
  logic [15:0] db16;
  logic [3:0]  op16;
  logic [15:0] ad16, ab16, pc16;
  logic        co16, st16;

  ab_byte_unit #(.W(8)) u8 (
    .clk(clk), .rst_n(rst8_n), .ff(ff8), .ci(ci8), .db(db8), .op(op8),
    .fix_en(fix8), .ld_tmp(ldt8), .ld_pc(ldp8), .inc_pc(inc8),
    .ad(ad8), .ab(ab8), .pc(pc8), .co(co8), .stall(st8)
  );

  ab_byte_unit #(.W(16)) u16 (
    .clk(clk), .rst_n(rst16_n), .ff(ff16), .ci(ci16), .db(db16), .op(op16),
    .fix_en(fix16), .ld_tmp(ldt16), .ld_pc(ldp16), .inc_pc(inc16),
    .ad(ad16), .ab(ab16), .pc(pc16), .co(co16), .stall(st16)
  );

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  event sb_ev;

  // Monitor: drain expectations on every falling edge or on demand.
  always begin
    @(negedge clk or sb_ev);
    while (q.size() > 0) begin
      exp_t        e;
      logic [15:0] act;
      e = q.pop_front();
      case (e.sig)
        S_AD:    act = e.w16 ? ad16 : {8'h00, ad8};
        S_AB:    act = e.w16 ? ab16 : {8'h00, ab8};
        S_PC:    act = e.w16 ? pc16 : {8'h00, pc8};
        S_ST:    act = {15'h0, e.w16 ? st16 : st8};
        default: act = {15'h0, e.w16 ? co16 : co8};
      endcase
      checks++;
      if (act !== e.val) begin
        errors++;
        $display("FAIL %s: got %h expected %h at %0t", e.name, act, e.val, $time);
      end
    end
  end

  task automatic ex(input string n, input int s, input logic [15:0] v, input bit w16);
    exp_t e;
    e.name = n; e.sig = s; e.val = v; e.w16 = w16;
    q.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drv8(input logic [3:0] op, input logic [7:0] db, input logic ci,
                      input logic fix, input logic ff, input logic ldt,
                      input logic ldp, input logic inc);
    op8 = op; db8 = db; ci8 = ci; fix8 = fix; ff8 = ff;
    ldt8 = ldt; ldp8 = ldp; inc8 = inc;
  endtask

  initial begin
    rst8_n = 1'b0; rst16_n = 1'b0;
    drv8(OP_ZERO, 8'h00, 0, 0, 0, 0, 0, 0);
    ff16 = 0; ci16 = 0; db16 = '0; op16 = OP_ZERO; fix16 = 0; ldt16 = 0; ldp16 = 0; inc16 = 0;
    tick; tick;
    ex("rst_ab", S_AB, 16'h00FF, 0);
    ex("rst_pc", S_PC, 16'h0000, 0);
    ex("rst_stall", S_ST, 16'h0, 0);
    ex("rst16_ab", S_AB, 16'hFFFF, 1);

    // Release, 0+0+ci
    tick;
    rst8_n = 1'b1;
    drv8(OP_ZERO, 8'h00, 1, 0, 0, 0, 0, 0);
    ex("zero_ad", S_AD, 16'h0001, 0);
    ex("zero_co", S_CO, 16'h0, 0);
    tick;
    ex("zero_ab", S_AB, 16'h0001, 0);

    // Page-cross: deferred carry gives a stalled second cycle
    drv8(OP_DB, 8'h12, 0, 0, 0, 0, 0, 0);
    tick;
    ex("ld12_ab", S_AB, 16'h0012, 0);
    drv8(OP_DB, 8'h34, 1, 1, 0, 0, 0, 0);
    ex("px_ad", S_AD, 16'h0034, 0);
    ex("px_idle_stall", S_ST, 16'h0, 0);
    tick;
    ex("px_ab", S_AB, 16'h0034, 0);
    ex("px_stall", S_ST, 16'h1, 0);
    drv8(OP_ZERO, 8'h00, 0, 0, 0, 0, 0, 0);
    ex("fix_ad", S_AD, 16'h0035, 0);
    ex("fix_co", S_CO, 16'h0, 0);
    tick;
    ex("fix_ab", S_AB, 16'h0035, 0);
    ex("fix_stall", S_ST, 16'h0, 0);

    // No cross
    drv8(OP_DB, 8'h34, 0, 1, 0, 0, 0, 0);
    ex("nox_ad", S_AD, 16'h0034, 0);
    tick;
    ex("nox_ab", S_AB, 16'h0034, 0);
    ex("nox_stall", S_ST, 16'h0, 0);
    drv8(OP_DB, 8'h00, 0, 0, 0, 0, 0, 0);
    tick;
    drv8(OP_ABM1, 8'h00, 0, 0, 0, 0, 0, 0);
    ex("abm1_ad", S_AD, 16'h00FF, 0);
    ex("abm1_co", S_CO, 16'h0, 0);
    tick;
    ex("abm1_ab", S_AB, 16'h00FF, 0);

    // AB+1 wrap and PC load with increment wrap
    drv8(OP_AB, 8'h00, 1, 0, 0, 0, 1, 1);
    ex("wrap_ad", S_AD, 16'h0000, 0);
    ex("wrap_co", S_CO, 16'h1, 0);
    tick;
    ex("pcwrap_pc", S_PC, 16'h0000, 0);
    ex("wrap_ab", S_AB, 16'h0000, 0);
    drv8(OP_DB, 8'h7F, 0, 0, 0, 0, 0, 0);
    tick;
    ex("ld7f_ab", S_AB, 16'h007F, 0);
    drv8(OP_HOLD, 8'h00, 1, 0, 0, 0, 1, 0);
    ex("hold_ad", S_AD, 16'h007F, 0);
    ex("hold_co", S_CO, 16'h0, 0);
    tick;
    ex("pc7f_pc", S_PC, 16'h007F, 0);
    ex("hold_ab", S_AB, 16'h007F, 0);
    drv8(OP_HOLD, 8'h00, 1, 0, 1, 0, 1, 1);
    ex("ffpc_ad", S_AD, 16'h00FF, 0);
    ex("ffpc_co", S_CO, 16'h0, 0);
    tick;
    ex("ffpc_pc", S_PC, 16'h0080, 0);
    ex("ffpc_ab", S_AB, 16'h00FF, 0);

    // ff during FIXUP discards the deferred carry
    drv8(OP_DB, 8'h10, 0, 0, 0, 0, 0, 0);
    tick;
    ex("ld10_ab", S_AB, 16'h0010, 0);
    drv8(OP_AB, 8'h00, 1, 1, 0, 0, 0, 0);
    ex("ffx_ad", S_AD, 16'h0010, 0);
    tick;
    ex("ffx_stall", S_ST, 16'h1, 0);
    ex("ffx_ab", S_AB, 16'h0010, 0);
    drv8(OP_AB, 8'h00, 1, 1, 1, 0, 0, 0);
    ex("ffx_ff_ad", S_AD, 16'h00FF, 0);
    ex("ffx_ff_co", S_CO, 16'h0, 0);
    tick;
    ex("ffx_after_ab", S_AB, 16'h00FF, 0);
    ex("ffx_after_stall", S_ST, 16'h0, 0);
    drv8(OP_HOLD, 8'h00, 0, 0, 0, 0, 0, 0);
    ex("ffx_no11_ad", S_AD, 16'h00FF, 0);
    tick;
    ex("ffx_no11_ab", S_AB, 16'h00FF, 0);

    // TMP: same-cycle load reads old TMP; reserved op holds; PC operand
    drv8(OP_TMP, 8'h55, 0, 0, 0, 1, 0, 0);
    ex("tmp_old_ad", S_AD, 16'h0000, 0);
    tick;
    ex("tmp_old_ab", S_AB, 16'h0000, 0);
    drv8(OP_TMP, 8'h00, 0, 0, 0, 0, 0, 0);
    ex("tmp_new_ad", S_AD, 16'h0055, 0);
    tick;
    ex("tmp_new_ab", S_AB, 16'h0055, 0);
    drv8(4'b1110, 8'h00, 1, 0, 0, 0, 0, 0);
    ex("rsv_ad", S_AD, 16'h0055, 0);
    ex("rsv_co", S_CO, 16'h0, 0);
    tick;
    drv8(OP_PC, 8'h00, 1, 0, 0, 0, 0, 0);
    ex("pcop_ad", S_AD, 16'h0081, 0);
    tick;
    ex("pcop_ab", S_AB, 16'h0081, 0);

    // FIXUP carrying out of the slice, op ignored
    drv8(OP_DB, 8'hFF, 0, 0, 0, 0, 0, 0);
    tick;
    drv8(OP_AB, 8'h00, 1, 1, 0, 0, 0, 0);
    ex("fxc_ad0", S_AD, 16'h00FF, 0);
    ex("fxc_co0", S_CO, 16'h0, 0);
    tick;
    drv8(OP_DB, 8'h33, 0, 0, 0, 0, 0, 0);
    ex("fxc_stall", S_ST, 16'h1, 0);
    ex("fxc_ad", S_AD, 16'h0000, 0);
    ex("fxc_co", S_CO, 16'h1, 0);
    tick;
    ex("fxc_ab", S_AB, 16'h0000, 0);
    ex("fxc_stall_end", S_ST, 16'h0, 0);

    // W=16: TMP operand, then reset mid-FIXUP
    rst16_n = 1'b1;
    ldt16 = 1; db16 = 16'hABCD; op16 = OP_ZERO; ci16 = 0;
    tick;
    ex("w16_ab0", S_AB, 16'h0000, 1);
    ldt16 = 0; op16 = OP_TMP; ci16 = 1; fix16 = 0;
    ex("w16_tmp_ad", S_AD, 16'hABCE, 1);
    ex("w16_tmp_co", S_CO, 16'h0, 1);
    tick;
    ex("w16_tmp_ab", S_AB, 16'hABCE, 1);
    fix16 = 1;
    ex("w16_px_ad", S_AD, 16'hABCD, 1);
    tick;
    ex("w16_fix_stall", S_ST, 16'h1, 1);
    ex("w16_fix_ab", S_AB, 16'hABCD, 1);
    ex("w16_fix_ad", S_AD, 16'hABCE, 1);
    -> sb_ev;
    #1;
    rst16_n = 1'b0;
    #1;
    ex("w16_rst_stall", S_ST, 16'h0, 1);
    ex("w16_rst_ab", S_AB, 16'hFFFF, 1);
    ex("w16_rst_pc", S_PC, 16'h0000, 1);
    -> sb_ev;
    tick;
    rst16_n = 1'b1;
    tick;

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound so the bench always ends.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
